// File: rtl/contador_ad_param_2dig.sv
// Two-digit BCD up/down counter field with manual adjust, auto-repeat and load.
// Counts in binary between MIN_VAL and MAX_VAL; data_out is the packed BCD view.
module contador_ad_param_2dig #(
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 59,
    parameter int SEL_CODE = 9,
    parameter int TICK_DIV = 13000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en_count,
    input  logic       enUP,
    input  logic       enDOWN,
    input  logic       inc_in,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic [7:0] data_out,
    output logic       carry_out,
    output logic       borrow_out,
    output logic       load_err
);
    // state    | meaning
    // ADJ_IDLE | no adjust request last cycle
    // ADJ_UP   | increment request held last cycle
    // ADJ_DOWN | decrement request held last cycle
    typedef enum logic [1:0] {
        ADJ_IDLE = 2'd0,
        ADJ_UP   = 2'd1,
        ADJ_DOWN = 2'd2
    } adj_t;

    localparam int         TW    = $clog2(TICK_DIV);
    localparam logic [6:0] MIN_C = 7'(MIN_VAL);
    localparam logic [6:0] MAX_C = 7'(MAX_VAL);
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

    adj_t          adj_state, adj_next;
    logic [6:0]    count, count_next;
    logic [TW-1:0] timer, timer_next;
    logic          carry_next, borrow_next, err_next;
    logic          step, do_inc, do_dec, load_ok;
    logic [7:0]    load_bin;
    logic [6:0]    units;
    logic [3:0]    tens;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adj_state  <= ADJ_IDLE;
            count      <= MIN_C;
            timer      <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            adj_state  <= adj_next;
            count      <= count_next;
            timer      <= timer_next;
            carry_out  <= carry_next;
            borrow_out <= borrow_next;
            load_err   <= err_next;
        end
    end

    always_comb begin
        adj_next    = ADJ_IDLE;
        timer_next  = '0;
        step        = 1'b0;
        count_next  = count;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        err_next    = 1'b0;

        if (en_count == 4'(SEL_CODE) && (enUP ^ enDOWN))
            adj_next = enUP ? ADJ_UP : ADJ_DOWN;

        // A new or reversed request steps at once; a held one steps on timer wrap.
        if (adj_next != ADJ_IDLE) begin
            if (adj_next != adj_state || timer == TMAX)
                step = 1'b1;
            else
                timer_next = timer + 1'b1;
        end

        load_bin = {4'd0, load_data[7:4]} * 8'd10 + {4'd0, load_data[3:0]};
        load_ok  = (load_data[7:4] <= 4'd9) && (load_data[3:0] <= 4'd9) &&
                   (int'(load_bin) >= MIN_VAL) && (int'(load_bin) <= MAX_VAL);

        do_inc = !load && ((step && adj_next == ADJ_UP) || (!step && inc_in));
        do_dec = !load && step && adj_next == ADJ_DOWN;

        if (load) begin
            if (load_ok)
                count_next = load_bin[6:0];
            else
                err_next = 1'b1;
        end else if (do_inc) begin
            if (count == MAX_C) begin
                count_next = MIN_C;
                carry_next = 1'b1;
            end else begin
                count_next = count + 7'd1;
            end
        end else if (do_dec) begin
            if (count == MIN_C) begin
                count_next  = MAX_C;
                borrow_next = 1'b1;
            end else begin
                count_next = count - 7'd1;
            end
        end
    end

    always_comb begin
        tens  = 4'd0;
        units = count;
        for (int i = 0; i < 9; i++) begin
            if (units >= 7'd10) begin
                units = units - 7'd10;
                tens  = tens + 4'd1;
            end
        end
        data_out = {tens, units[3:0]};
    end
endmodule

// File: tb/tb_contador_ad_param_2dig.sv
// Bench for contador_ad_param_2dig: default instance plus a MIN=1/MAX=31 instance,
// both with a 4-cycle repeat period, driven from a vector table and a scoreboard.
module tb_contador_ad_param_2dig;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] en_count = 4'd0;
    logic       enUP = 1'b0, enDOWN = 1'b0, inc_in = 1'b0, load = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic [7:0] d0, d1;
    logic       c0, b0, e0, c1, b1, e1;

    always #5 clk = ~clk;

    contador_ad_param_2dig #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .inc_in(inc_in), .load(load), .load_data(load_data),
        .data_out(d0), .carry_out(c0), .borrow_out(b0), .load_err(e0)
    );

    contador_ad_param_2dig #(.MIN_VAL(1), .MAX_VAL(31), .TICK_DIV(4)) dut2 (
        .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
        .inc_in(inc_in), .load(load), .load_data(load_data),
        .data_out(d1), .carry_out(c1), .borrow_out(b1), .load_err(e1)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] en;
        logic       up, dn, inc, ld;
        logic [7:0] ldd;
        logic       dsel;
        logic [7:0] exp_d;
        logic       exp_c, exp_b, exp_e;
    } vec_t;

    typedef struct {
        string       name;
        logic        dsel;
        logic [10:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string name, logic rst, logic [3:0] en, logic up, logic dn,
                                logic inc, logic ld, logic [7:0] ldd, logic dsel,
                                logic [7:0] d, logic c, logic b, logic e);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.up = up; v.dn = dn; v.inc = inc;
        v.ld = ld; v.ldd = ldd; v.dsel = dsel; v.exp_d = d; v.exp_c = c; v.exp_b = b;
        v.exp_e = e;
        return v;
    endfunction

    task automatic drive(input logic [3:0] en, input logic up, input logic dn,
                         input logic inc, input logic ld, input logic [7:0] ldd);
        en_count = en; enUP = up; enDOWN = dn; inc_in = inc; load = ld; load_data = ldd;
    endtask

    task automatic push(input string name, input logic dsel, input logic [7:0] d,
                        input logic c, input logic b, input logic e);
        sb_t s;
        s.name = name; s.dsel = dsel; s.exp = {d, c, b, e};
        sb.push_back(s);
    endtask

    task automatic check_pop();
        sb_t s;
        logic [10:0] act;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            s   = sb.pop_front();
            act = s.dsel ? {d1, c1, b1, e1} : {d0, c0, b0, e0};
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s (dut%0d): got data=%h carry=%b borrow=%b err=%b, expected data=%h carry=%b borrow=%b err=%b",
                         s.name, s.dsel, act[10:3], act[2], act[1], act[0],
                         s.exp[10:3], s.exp[2], s.exp[1], s.exp[0]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // Narrow-range instance: reset value, wrap, and rejected loads.
        vecs.push_back(mk("m2_reset", 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk("m2_ld31",  0, 0, 0, 0, 0, 1, 8'h31, 1, 8'h31, 0, 0, 0));
        vecs.push_back(mk("m2_wrap",  0, 0, 0, 0, 1, 0, 8'h00, 1, 8'h01, 1, 0, 0));
        vecs.push_back(mk("m2_idle",  0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk("m2_ld32",  0, 0, 0, 0, 0, 1, 8'h32, 1, 8'h01, 0, 0, 1));
        vecs.push_back(mk("m2_ld1A",  0, 0, 0, 0, 0, 1, 8'h1A, 1, 8'h01, 0, 0, 1));
        vecs.push_back(mk("m2_ld00",  0, 0, 0, 0, 0, 1, 8'h00, 1, 8'h01, 0, 0, 1));
        vecs.push_back(mk("m2_idle2", 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk("m2_dn",    0, 9, 0, 1, 0, 0, 8'h00, 1, 8'h31, 0, 1, 0));
        vecs.push_back(mk("m2_hold",  0, 9, 0, 1, 0, 0, 8'h00, 1, 8'h31, 0, 0, 0));
        // Default instance: auto-repeat at 4-cycle period after a fresh reset.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk("rep_up", (i == 0), 9, 1, 0, 0, 0, 8'h00, 0,
                              8'(1 + i / 4), 0, 0, 0));
        vecs.push_back(mk("rel",      0, 9, 0, 0, 0, 0, 8'h00, 0, 8'h03, 0, 0, 0));
        vecs.push_back(mk("ld_pri",   0, 9, 1, 0, 1, 1, 8'h20, 0, 8'h20, 0, 0, 0));
        vecs.push_back(mk("ld_pri2",  0, 9, 1, 0, 0, 0, 8'h00, 0, 8'h20, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("both",  0, 9, 1, 1, 0, 0, 8'h00, 0, 8'h20, 0, 0, 0));
        vecs.push_back(mk("ld59",     0, 0, 0, 0, 0, 1, 8'h59, 0, 8'h59, 0, 0, 0));
        vecs.push_back(mk("inc_wrap", 0, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk("post_c",   0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk("dn_wrap",  0, 9, 0, 1, 0, 0, 8'h00, 0, 8'h59, 0, 1, 0));
        vecs.push_back(mk("post_b",   0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h59, 0, 0, 0));
        vecs.push_back(mk("ld10",     0, 0, 0, 0, 0, 1, 8'h10, 0, 8'h10, 0, 0, 0));
        vecs.push_back(mk("up_a",     0, 9, 1, 0, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk("dir_chg",  0, 9, 0, 1, 0, 0, 8'h00, 0, 8'h10, 0, 0, 0));
        vecs.push_back(mk("dn_hold",  0, 9, 0, 1, 0, 0, 8'h00, 0, 8'h10, 0, 0, 0));
        vecs.push_back(mk("inc",      0, 0, 0, 0, 1, 0, 8'h00, 0, 8'h11, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("sel8",  0, 8, 1, 0, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk("ld60",     0, 0, 0, 0, 0, 1, 8'h60, 0, 8'h11, 0, 0, 1));
        vecs.push_back(mk("ld5A",     0, 0, 0, 0, 0, 1, 8'h5A, 0, 8'h11, 0, 0, 1));
        vecs.push_back(mk("post_e",   0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0));

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        push("rst_async0", 0, 8'h00, 0, 0, 0); check_pop();
        push("rst_async1", 1, 8'h01, 0, 0, 0); check_pop();
        @(negedge clk) reset = 1'b0;

        foreach (vecs[k]) begin
            if (vecs[k].rst) begin
                @(negedge clk);
                reset = 1'b1;
                drive(0, 0, 0, 0, 0, 8'h00);
                @(negedge clk) reset = 1'b0;
            end
            @(negedge clk);
            drive(vecs[k].en, vecs[k].up, vecs[k].dn, vecs[k].inc, vecs[k].ld, vecs[k].ldd);
            push(vecs[k].name, vecs[k].dsel, vecs[k].exp_d, vecs[k].exp_c,
                 vecs[k].exp_b, vecs[k].exp_e);
            @(posedge clk);
            #1 check_pop();
        end

        // Reset between edges while a wrapping repeat step is pending.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 8'h58);
        push("ld58", 0, 8'h58, 0, 0, 0);
        @(posedge clk);
        #1 check_pop();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(9, 1, 0, 0, 0, 8'h00);
            push("rep59", 0, 8'h59, 0, 0, 0);
            @(posedge clk);
            #1 check_pop();
        end
        #2 reset = 1'b1;
        #1;
        push("mid_rst", 0, 8'h00, 0, 0, 0); check_pop();
        push("rst_hold", 0, 8'h00, 0, 0, 0);
        @(posedge clk);
        #1 check_pop();
        @(negedge clk) reset = 1'b0;
        push("rst_rel_step", 0, 8'h01, 0, 0, 0);
        @(posedge clk);
        #1 check_pop();
        push("rst_rel_hold", 0, 8'h01, 0, 0, 0);
        @(posedge clk);
        #1 check_pop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
